pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 34 +++
 rtl/pipe_hazard_ctrl_if.sv | 55 +++++
 rtl/pipe_hazard_ctrl_fwd_sel.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg -- shared types for the pipeline hazard controller.
//   ctrl_state_e : hazard FSM state encodings (also exported on the debug port)
//   fwd_sel_e    : operand-source select codes driven to the execute muxes
//   regHit()     : "source register is produced by this destination" compare
// No ports (package). Optional feature macro used by importers: FORWARD_EN.
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int REG_W = 3;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_LDSTALL = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_MEMWAIT = 3'd3,
    ST_HALT    = 3'd4
  } ctrl_state_e;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_EXMEM   = 2'd1,
    FWD_MEMWB   = 2'd2
  } fwd_sel_e;

  // r0 is an ordinary register here, so no special case for index 0.
  function automatic logic regHit(input logic srcVld, input reg_idx_t srcReg,
                                  input logic dstWrt, input reg_idx_t dstReg);
    return srcVld & dstWrt & (srcReg == dstReg);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if -- bundle between the pipeline datapath and the hazard
// controller.
//   master : pipeline side; drives stage register ids/flags and redirect /
//            memory / halt events, receives stall, bubble, flush, forwarding
//            selects, halt and debug state.
//   slave  : hazard controller side (directions reversed).
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  // decode stage sources
  reg_idx_t    idRs;
  reg_idx_t    idRt;
  logic        idRsVld;
  logic        idRtVld;
  // execute / memory / writeback destinations
  reg_idx_t    exWriteReg;
  logic        exRegWrt;
  logic        exMemToReg;
  reg_idx_t    memWriteReg;
  logic        memRegWrt;
  reg_idx_t    wbWriteReg;
  logic        wbRegWrt;
  // events
  logic        doBranch;
  logic        jump;
  logic        memBusy;
  logic        haltIn;
  // controls back to the pipeline
  logic        stall;
  logic        bubble;
  logic        flushPipe;
  logic [1:0]  fwdASel;
  logic [1:0]  fwdBSel;
  logic        haltOut;
  logic [2:0]  state;

  modport master (
    output idRs, idRt, idRsVld, idRtVld,
    output exWriteReg, exRegWrt, exMemToReg,
    output memWriteReg, memRegWrt, wbWriteReg, wbRegWrt,
    output doBranch, jump, memBusy, haltIn,
    input  stall, bubble, flushPipe, fwdASel, fwdBSel, haltOut, state
  );

  modport slave (
    input  idRs, idRt, idRsVld, idRtVld,
    input  exWriteReg, exRegWrt, exMemToReg,
    input  memWriteReg, memRegWrt, wbWriteReg, wbRegWrt,
    input  doBranch, jump, memBusy, haltIn,
    output stall, bubble, flushPipe, fwdASel, fwdBSel, haltOut, state
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// ---------------------------------------------------------------------------
// fwd_sel -- forwarding source select for one execute operand.
// Ports:
//   srcReg/srcVld          : decode-stage source register and its use flag
//   memWriteReg/memRegWrt  : EX/MEM destination and write flag
//   wbWriteReg/wbRegWrt    : MEM/WB destination and write flag
//   fwdSel                 : FWD_EXMEM, else FWD_MEMWB, else FWD_REGFILE
// The younger (EX/MEM) result wins when both stages write the same register.
// ---------------------------------------------------------------------------
module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  reg_idx_t srcReg,
  input  logic     srcVld,
  input  reg_idx_t memWriteReg,
  input  logic     memRegWrt,
  input  reg_idx_t wbWriteReg,
  input  logic     wbRegWrt,
  output fwd_sel_e fwdSel
);

  always_comb begin
    fwdSel = FWD_REGFILE;
    if (regHit(srcVld, srcReg, memRegWrt, memWriteReg)) begin
      fwdSel = FWD_EXMEM;
    end else if (regHit(srcVld, srcReg, wbRegWrt, wbWriteReg)) begin
      fwdSel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl -- stall / bubble / flush / forwarding control for a
// 5-stage pipeline.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-low reset
//   hz   : pipe_hazard_ctrl_if.slave (stage ids, events in; controls out)
// Parameter:
//   FLUSH_CYCLES : cycles flushPipe stays high after the redirect cycle (1..7)
// Build option:
//   FORWARD_EN   : when defined, operands are forwarded and only load-use
//                  hazards stall (one LDSTALL cycle). When undefined,
//                  forwarding selects are tied to 0 and any in-flight
//                  producer of a source stalls RUN until it retires.
// All outputs are forced to 0 while rst is low, regardless of inputs.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  ctrl_state_e stateReg, stateNext;
  logic [2:0]  cntReg, cntNext;
  logic        pendReg, pendNext;

  logic        stallC, bubbleC, flushC, haltC;
  logic        redirect;
  logic        exHit;
  logic        dataHazard;
  fwd_sel_e    fwdA, fwdB;
  logic [1:0]  fwdAOut, fwdBOut;

  // One compare per operand against EX/MEM and MEM/WB.
  fwd_sel uFwdA (
    .srcReg     (hz.idRs),
    .srcVld     (hz.idRsVld),
    .memWriteReg(hz.memWriteReg),
    .memRegWrt  (hz.memRegWrt),
    .wbWriteReg (hz.wbWriteReg),
    .wbRegWrt   (hz.wbRegWrt),
    .fwdSel     (fwdA)
  );

  fwd_sel uFwdB (
    .srcReg     (hz.idRt),
    .srcVld     (hz.idRtVld),
    .memWriteReg(hz.memWriteReg),
    .memRegWrt  (hz.memRegWrt),
    .wbWriteReg (hz.wbWriteReg),
    .wbRegWrt   (hz.wbRegWrt),
    .fwdSel     (fwdB)
  );

  assign redirect = hz.doBranch | hz.jump;
  assign exHit    = regHit(hz.idRsVld, hz.idRs, hz.exRegWrt, hz.exWriteReg) |
                    regHit(hz.idRtVld, hz.idRt, hz.exRegWrt, hz.exWriteReg);

`ifdef FORWARD_EN
  localparam bit USE_LDSTALL = 1'b1;
  // Only a load in execute cannot be forwarded in time.
  assign dataHazard = exHit & hz.exMemToReg;
  assign fwdAOut    = fwdA;
  assign fwdBOut    = fwdB;
`else
  localparam bit USE_LDSTALL = 1'b0;
  logic unusedLoadFlag;
  // Without forwarding every in-flight producer blocks decode; the stall is
  // re-evaluated each cycle as the producer drains toward writeback.
  assign dataHazard     = exHit | (fwdA != FWD_REGFILE) | (fwdB != FWD_REGFILE);
  assign fwdAOut        = 2'd0;
  assign fwdBOut        = 2'd0;
  assign unusedLoadFlag = hz.exMemToReg;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg <= ST_RUN;
      cntReg   <= 3'd0;
      pendReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      pendReg  <= pendNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    pendNext  = pendReg;
    stallC    = 1'b0;
    bubbleC   = 1'b0;
    flushC    = 1'b0;
    haltC     = 1'b0;
    unique case (stateReg)
      ST_RUN: begin
        if (hz.haltIn) begin
          stateNext = ST_HALT;
        end else if (hz.memBusy) begin
          stateNext = ST_MEMWAIT;
        end else if (redirect) begin
          // Squash starts in the redirect cycle itself.
          flushC    = 1'b1;
          cntNext   = FLUSH_LOAD;
          stateNext = ST_FLUSH;
        end else if (dataHazard) begin
          stallC  = 1'b1;
          bubbleC = 1'b1;
          if (USE_LDSTALL) begin
            stateNext = ST_LDSTALL;
          end
        end
      end
      ST_LDSTALL: begin
        stateNext = ST_RUN;
      end
      ST_FLUSH: begin
        flushC = 1'b1;
        if (cntReg == 3'd0) begin
          stateNext = ST_RUN;
        end else begin
          cntNext = cntReg - 3'd1;
        end
      end
      ST_MEMWAIT: begin
        stallC = 1'b1;
        // A redirect seen while frozen must not be lost.
        if (redirect) begin
          pendNext = 1'b1;
        end
        if (!hz.memBusy) begin
          if (pendReg | redirect) begin
            pendNext  = 1'b0;
            cntNext   = FLUSH_LOAD;
            stateNext = ST_FLUSH;
          end else begin
            stateNext = ST_RUN;
          end
        end
      end
      ST_HALT: begin
        haltC  = 1'b1;
        stallC = 1'b1;
        flushC = 1'b1;
      end
      default: begin
        stateNext = ST_RUN;
      end
    endcase
  end

  // Gate with rst so outputs drop as soon as reset asserts, not at the edge.
  assign hz.stall     = rst & stallC;
  assign hz.bubble    = rst & bubbleC;
  assign hz.flushPipe = rst & flushC;
  assign hz.haltOut   = rst & haltC;
  assign hz.fwdASel   = rst ? fwdAOut : 2'd0;
  assign hz.fwdBSel   = rst ? fwdBOut : 2'd0;
  assign hz.state     = stateReg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl -- directed bench for pipe_hazard_ctrl (FLUSH_CYCLES=2).
// Covers both builds of FORWARD_EN. Inputs change 1 time unit after the rising
// edge; outputs are sampled 1 unit later, well before the next edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk(clk),
    .rst(rst),
    .hz (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    bus.idRs        = 3'd0;
    bus.idRt        = 3'd0;
    bus.idRsVld     = 1'b0;
    bus.idRtVld     = 1'b0;
    bus.exWriteReg  = 3'd0;
    bus.exRegWrt    = 1'b0;
    bus.exMemToReg  = 1'b0;
    bus.memWriteReg = 3'd0;
    bus.memRegWrt   = 1'b0;
    bus.wbWriteReg  = 3'd0;
    bus.wbRegWrt    = 1'b0;
    bus.doBranch    = 1'b0;
    bus.jump        = 1'b0;
    bus.memBusy     = 1'b0;
    bus.haltIn      = 1'b0;
  endtask

  task automatic test_reset();
    clearIn();
    rst = 1'b0;
    // Inputs that would raise every output if reset did not gate them.
    bus.doBranch    = 1'b1;
    bus.memWriteReg = 3'd1;
    bus.memRegWrt   = 1'b1;
    bus.idRs        = 3'd1;
    bus.idRsVld     = 1'b1;
    bus.idRt        = 3'd1;
    bus.idRtVld     = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (bus.state !== 3'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", bus.state);
    end
    checks++;
    if ({bus.stall, bus.bubble, bus.flushPipe, bus.haltOut} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got stall/bubble/flush/halt=%b want 0000",
                         {bus.stall, bus.bubble, bus.flushPipe, bus.haltOut});
    end
    checks++;
    if ({bus.fwdASel, bus.fwdBSel} !== 4'b0000) begin
      errors++; $display("FAIL reset_fwd: got fwdA=%0d fwdB=%0d want 0 0", bus.fwdASel, bus.fwdBSel);
    end
    clearIn();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.state !== 3'd0) begin
      errors++; $display("FAIL reset_release_state: got %0d want 0", bus.state);
    end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    tick();
    bus.exRegWrt   = 1'b1;
    bus.exMemToReg = 1'b1;
    bus.exWriteReg = 3'd3;
    bus.idRs       = 3'd3;
    bus.idRsVld    = 1'b1;
    #1;
    checks++;
    if ({bus.stall, bus.bubble} !== 2'b11 || bus.state !== 3'd0) begin
      errors++; $display("FAIL loaduse_detect: got stall=%b bubble=%b state=%0d want 1 1 0",
                         bus.stall, bus.bubble, bus.state);
    end
    tick();
    clearIn();
    #1;
`ifdef FORWARD_EN
    checks++;
    if (bus.state !== 3'd1) begin
      errors++; $display("FAIL loaduse_ldstall_state: got %0d want 1", bus.state);
    end
`else
    checks++;
    if (bus.state !== 3'd0) begin
      errors++; $display("FAIL loaduse_noldstall_state: got %0d want 0", bus.state);
    end
`endif
    checks++;
    if ({bus.stall, bus.bubble} !== 2'b00) begin
      errors++; $display("FAIL loaduse_one_cycle: got stall=%b bubble=%b want 0 0", bus.stall, bus.bubble);
    end
    tick();
    #1;
    checks++;
    if (bus.state !== 3'd0 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL loaduse_back_to_run: got state=%0d stall=%b want 0 0", bus.state, bus.stall);
    end
    $display("test_load_use done");
  endtask

  task automatic test_branch_flush();
    tick();
    bus.doBranch = 1'b1;
    #1;
    checks++;
    if (bus.flushPipe !== 1'b1 || bus.state !== 3'd0 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL branch_cycle0: got flush=%b state=%0d stall=%b want 1 0 0",
                         bus.flushPipe, bus.state, bus.stall);
    end
    tick();
    bus.doBranch = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      #1;
      checks++;
      if (bus.flushPipe !== 1'b1 || bus.state !== 3'd2) begin
        errors++; $display("FAIL branch_flush_c%0d: got flush=%b state=%0d want 1 2",
                           c, bus.flushPipe, bus.state);
      end
      tick();
    end
    #1;
    checks++;
    if (bus.flushPipe !== 1'b0 || bus.state !== 3'd0) begin
      errors++; $display("FAIL branch_end: got flush=%b state=%0d want 0 0", bus.flushPipe, bus.state);
    end
    $display("test_branch_flush done");
  endtask

  task automatic test_memwait_redirect();
    logic [2:0] expState [8] = '{3'd0, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd0};
    logic       expStall [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       expFlush [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int         stallCount = 0;
    tick();
    for (int c = 0; c < 8; c++) begin
      bus.memBusy = (c < 4);
      bus.jump    = (c == 1);
      #1;
      if (bus.stall === 1'b1) stallCount++;
      checks++;
      if (bus.state !== expState[c] || bus.stall !== expStall[c] || bus.flushPipe !== expFlush[c]) begin
        errors++; $display("FAIL memwait_c%0d: got state=%0d stall=%b flush=%b want %0d %b %b",
                           c, bus.state, bus.stall, bus.flushPipe, expState[c], expStall[c], expFlush[c]);
      end
      tick();
    end
    clearIn();
    checks++;
    if (stallCount != 4) begin
      errors++; $display("FAIL memwait_stall_count: got %0d want 4", stallCount);
    end
    $display("test_memwait_redirect done");
  endtask

`ifdef FORWARD_EN
  task automatic test_forward();
    tick();
    bus.memWriteReg = 3'd5;
    bus.wbWriteReg  = 3'd5;
    bus.memRegWrt   = 1'b1;
    bus.wbRegWrt    = 1'b1;
    bus.idRt        = 3'd5;
    bus.idRtVld     = 1'b1;
    #1;
    checks++;
    if (bus.fwdBSel !== 2'd1 || bus.fwdASel !== 2'd0) begin
      errors++; $display("FAIL fwd_exmem: got fwdB=%0d fwdA=%0d want 1 0", bus.fwdBSel, bus.fwdASel);
    end
    bus.memRegWrt = 1'b0;
    #1;
    checks++;
    if (bus.fwdBSel !== 2'd2) begin
      errors++; $display("FAIL fwd_memwb: got fwdB=%0d want 2", bus.fwdBSel);
    end
    bus.idRs    = 3'd5;
    bus.idRsVld = 1'b1;
    #1;
    checks++;
    if (bus.fwdASel !== 2'd2 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL fwd_a_memwb: got fwdA=%0d stall=%b want 2 0", bus.fwdASel, bus.stall);
    end
    bus.idRtVld = 1'b0;
    #1;
    checks++;
    if (bus.fwdBSel !== 2'd0) begin
      errors++; $display("FAIL fwd_flag_clear: got fwdB=%0d want 0", bus.fwdBSel);
    end
    clearIn();
    // Non-load producer in execute is forwarded later, so no stall.
    bus.exRegWrt   = 1'b1;
    bus.exWriteReg = 3'd6;
    bus.idRs       = 3'd6;
    bus.idRsVld    = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("FAIL fwd_alu_nostall: got stall=%b want 0", bus.stall);
    end
    clearIn();
    $display("test_forward done");
  endtask
`else
  task automatic test_no_forward();
    tick();
    bus.wbWriteReg = 3'd2;
    bus.wbRegWrt   = 1'b1;
    bus.idRs       = 3'd2;
    bus.idRsVld    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.stall !== 1'b1 || bus.bubble !== 1'b1 || bus.fwdASel !== 2'd0 || bus.state !== 3'd0) begin
        errors++; $display("FAIL nofwd_wb_c%0d: got stall=%b bubble=%b fwdA=%0d state=%0d want 1 1 0 0",
                           c, bus.stall, bus.bubble, bus.fwdASel, bus.state);
      end
      tick();
    end
    bus.wbRegWrt = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("FAIL nofwd_release: got stall=%b want 0", bus.stall);
    end
    clearIn();
    bus.memWriteReg = 3'd4;
    bus.memRegWrt   = 1'b1;
    bus.idRt        = 3'd4;
    bus.idRtVld     = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b1 || bus.fwdBSel !== 2'd0) begin
      errors++; $display("FAIL nofwd_mem: got stall=%b fwdB=%0d want 1 0", bus.stall, bus.fwdBSel);
    end
    clearIn();
    bus.exRegWrt   = 1'b1;
    bus.exWriteReg = 3'd6;
    bus.idRs       = 3'd6;
    bus.idRsVld    = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++; $display("FAIL nofwd_ex_alu: got stall=%b want 1", bus.stall);
    end
    clearIn();
    $display("test_no_forward done");
  endtask
`endif

  task automatic test_halt_reset();
    tick();
    bus.haltIn = 1'b1;
    #1;
    checks++;
    if (bus.haltOut !== 1'b0 || bus.state !== 3'd0) begin
      errors++; $display("FAIL halt_entry: got haltOut=%b state=%0d want 0 0", bus.haltOut, bus.state);
    end
    tick();
    bus.haltIn      = 1'b0;
    bus.memWriteReg = 3'd1;
    bus.memRegWrt   = 1'b1;
    bus.idRs        = 3'd1;
    bus.idRsVld     = 1'b1;
    bus.doBranch    = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if ({bus.haltOut, bus.stall, bus.flushPipe} !== 3'b111 || bus.state !== 3'd4) begin
        errors++; $display("FAIL halt_hold_c%0d: got halt/stall/flush=%b state=%0d want 111 4",
                           c, {bus.haltOut, bus.stall, bus.flushPipe}, bus.state);
      end
      tick();
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.haltOut, bus.stall, bus.bubble, bus.flushPipe} !== 4'b0000 ||
        {bus.fwdASel, bus.fwdBSel} !== 4'b0000 || bus.state !== 3'd0) begin
      errors++; $display("FAIL halt_async_reset: got halt/stall/bubble/flush=%b fwdA=%0d fwdB=%0d state=%0d want 0000 0 0 0",
                         {bus.haltOut, bus.stall, bus.bubble, bus.flushPipe}, bus.fwdASel, bus.fwdBSel, bus.state);
    end
    clearIn();
    #1;
    rst = 1'b1;
    tick();
    #1;
    checks++;
    if (bus.state !== 3'd0 || bus.haltOut !== 1'b0) begin
      errors++; $display("FAIL halt_after_reset: got state=%0d haltOut=%b want 0 0", bus.state, bus.haltOut);
    end
    $display("test_halt_reset done");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_load_use();
    test_branch_flush();
    test_memwait_redirect();
`ifdef FORWARD_EN
    test_forward();
`else
    test_no_forward();
`endif
    test_halt_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
